// File: rtl/lift_pkg.sv
// Shared hall-call definitions: request codes, lift directions and the
// default request FIFO depth.
package lift_pkg;

    localparam int LIFT_DEPTH = 4;
    localparam int NUM_CALLS  = 6;

    localparam logic [2:0] REQ_NONE = 3'b000;
    localparam logic [2:0] REQ_1U   = 3'b001;
    localparam logic [2:0] REQ_2U   = 3'b010;
    localparam logic [2:0] REQ_3U   = 3'b011;
    localparam logic [2:0] REQ_2D   = 3'b110;
    localparam logic [2:0] REQ_3D   = 3'b111;
    localparam logic [2:0] REQ_4D   = 3'b100;

    typedef enum logic [1:0] {
        STAY = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } lift_dir_e;

    // Button index (bit0..5 = 1U, 2U, 3U, 2D, 3D, 4D) to request code.
    function automatic logic [2:0] call_code(input int idx);
        case (idx)
            0:       call_code = REQ_1U;
            1:       call_code = REQ_2U;
            2:       call_code = REQ_3U;
            3:       call_code = REQ_2D;
            4:       call_code = REQ_3D;
            5:       call_code = REQ_4D;
            default: call_code = REQ_NONE;
        endcase
    endfunction

    // Request code back to its one-hot button bit; NONE maps to no bit.
    function automatic logic [5:0] code_mask(input logic [2:0] code);
        case (code)
            REQ_1U:  code_mask = 6'b000001;
            REQ_2U:  code_mask = 6'b000010;
            REQ_3U:  code_mask = 6'b000100;
            REQ_2D:  code_mask = 6'b001000;
            REQ_3D:  code_mask = 6'b010000;
            REQ_4D:  code_mask = 6'b100000;
            default: code_mask = 6'b000000;
        endcase
    endfunction

    function automatic lift_dir_e code_dir(input logic [2:0] code);
        if (code == REQ_NONE)
            code_dir = STAY;
        else if (code[2])
            code_dir = DOWN;
        else
            code_dir = UP;
    endfunction

endpackage

// File: rtl/lift_req_fifo.sv
// Small circular request FIFO; head entry is visible combinationally on rdata
// and reads as zero when empty.
module lift_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Handshake: the caller asserts push only when !full or together with pop,
    // and pop only when !empty; the FIFO does not re-qualify either strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/lift_req_queue.sv
// Hall-call capture: edge-detects buttons, suppresses duplicates, and feeds
// waiting calls in fixed priority order into the request FIFO.
module lift_req_queue
    import lift_pkg::*;
#(
    parameter int DEPTH = LIFT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [5:0]               btn,
    input  logic                     done,
    output logic [2:0]               din,
    output logic                     q_empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [5:0]               pending
);

    logic [5:0] btn_q;
    logic [5:0] queued;
    logic [5:0] press;
    logic [5:0] waiting;
    logic [5:0] push_mask;
    logic [5:0] pop_mask;
    logic [2:0] push_code;
    logic       pop;
    logic       push;

    assign press   = btn & ~btn_q;
    assign waiting = pending & ~queued;
    assign pop     = done & ~q_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push    = (|waiting) & (~full | pop);

    always_comb begin
        push_mask = '0;
        push_code = REQ_NONE;
        for (int i = NUM_CALLS - 1; i >= 0; i--) begin
            if (waiting[i]) begin
                push_mask    = '0;
                push_mask[i] = 1'b1;
                push_code    = call_code(i);
            end
        end
    end

    assign pop_mask = pop ? code_mask(din) : '0;

    // A press landing on the cycle its own code is popped keeps the lamp lit
    // with queued clear, so the call goes back into the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q   <= '0;
            pending <= '0;
            queued  <= '0;
        end else begin
            btn_q   <= btn;
            pending <= (pending & ~pop_mask) | press;
            queued  <= (queued & ~pop_mask) | (push ? push_mask : 6'b000000);
        end
    end

    lift_req_fifo #(
        .DEPTH (DEPTH),
        .W     (3)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (push_code),
        .rdata (din),
        .count (count),
        .full  (full),
        .empty (q_empty)
    );

endmodule

// File: tb/tb_lift_req_queue.sv
// Bench for lift_req_queue: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_lift_req_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] btn = 6'b0;
    logic       done = 1'b0;
    logic [2:0] din;
    logic       q_empty;
    logic       full;
    logic [2:0] count;
    logic [5:0] pending;

    always #5 clk = ~clk;

    lift_req_queue #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .done    (done),
        .din     (din),
        .q_empty (q_empty),
        .full    (full),
        .count   (count),
        .pending (pending)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of codes plus per-button lamp/queued flags.
    logic [2:0] m_q[$];
    logic [5:0] m_pend = '0;
    logic [5:0] m_qd   = '0;
    logic [5:0] m_prev = '0;
    logic [2:0] code_tab [6];

    typedef struct {
        logic       r;
        logic [5:0] b;
        logic       d;
        logic [2:0] e_din;
        logic [2:0] e_cnt;
        logic [5:0] e_pend;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int code_idx(input logic [2:0] c);
        for (int i = 0; i < 6; i++)
            if (code_tab[i] == c) return i;
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [5:0] b, input logic d);
        bit pop_now;
        bit can_push;
        int widx;
        int pidx;
        if (!r) begin
            m_q.delete();
            m_pend = '0;
            m_qd   = '0;
            m_prev = '0;
            return;
        end
        pop_now  = d && (m_q.size() > 0);
        can_push = (m_q.size() < DEPTH) || pop_now;
        widx = -1;
        for (int i = 0; i < 6; i++) begin
            if (m_pend[i] && !m_qd[i]) begin
                widx = i;
                break;
            end
        end
        if (pop_now) begin
            pidx = code_idx(m_q[0]);
            void'(m_q.pop_front());
            if (pidx >= 0) begin
                m_pend[pidx] = 1'b0;
                m_qd[pidx]   = 1'b0;
            end
        end
        if (can_push && widx >= 0) begin
            m_q.push_back(code_tab[widx]);
            m_qd[widx] = 1'b1;
        end
        m_pend = m_pend | (b & ~m_prev);
        m_prev = b;
    endtask

    // Apply one clock with the given inputs, then compare every output to the model.
    task automatic cycle(input logic r, input logic [5:0] b, input logic d);
        logic [2:0] e_din;
        rst_n = r;
        btn   = b;
        done  = d;
        @(posedge clk);
        model_step(r, b, d);
        #1;
        e_din = (m_q.size() > 0) ? m_q[0] : 3'b000;
        check("model_din",     {5'b0, din},     {5'b0, e_din});
        check("model_count",   {5'b0, count},   8'(m_q.size()));
        check("model_q_empty", {7'b0, q_empty}, {7'b0, m_q.size() == 0});
        check("model_full",    {7'b0, full},    {7'b0, m_q.size() == DEPTH});
        check("model_pending", {2'b0, pending}, {2'b0, m_pend});
    endtask

    logic [2:0] obs[$];
    logic [2:0] exp_order [6];
    logic       r_rand;
    logic [5:0] b_rand;
    logic       d_rand;

    initial begin
        code_tab = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100};
        exp_order = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100};

        //          r     btn        d     din     cnt   pending
        tbl[0]  = '{1'b0, 6'b000000, 1'b0, 3'b000, 3'd0, 6'b000000};
        tbl[1]  = '{1'b1, 6'b000100, 1'b0, 3'b000, 3'd0, 6'b000100};
        tbl[2]  = '{1'b1, 6'b000000, 1'b0, 3'b011, 3'd1, 6'b000100};
        tbl[3]  = '{1'b1, 6'b000000, 1'b1, 3'b000, 3'd0, 6'b000000};
        tbl[4]  = '{1'b1, 6'b101001, 1'b0, 3'b000, 3'd0, 6'b101001};
        tbl[5]  = '{1'b1, 6'b000000, 1'b0, 3'b001, 3'd1, 6'b101001};
        tbl[6]  = '{1'b1, 6'b000000, 1'b0, 3'b001, 3'd2, 6'b101001};
        tbl[7]  = '{1'b1, 6'b000000, 1'b0, 3'b001, 3'd3, 6'b101001};
        tbl[8]  = '{1'b1, 6'b000000, 1'b1, 3'b110, 3'd2, 6'b101000};
        tbl[9]  = '{1'b1, 6'b000000, 1'b1, 3'b100, 3'd1, 6'b100000};
        tbl[10] = '{1'b1, 6'b000000, 1'b1, 3'b000, 3'd0, 6'b000000};
        tbl[11] = '{1'b1, 6'b000000, 1'b1, 3'b000, 3'd0, 6'b000000};

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].r, tbl[i].b, tbl[i].d);
            check($sformatf("vec%0d_din", i),     {5'b0, din},     {5'b0, tbl[i].e_din});
            check($sformatf("vec%0d_count", i),   {5'b0, count},   {5'b0, tbl[i].e_cnt});
            check($sformatf("vec%0d_pending", i), {2'b0, pending}, {2'b0, tbl[i].e_pend});
            check($sformatf("vec%0d_q_empty", i), {7'b0, q_empty}, {7'b0, tbl[i].e_cnt == 3'd0});
            check($sformatf("vec%0d_full", i),    {7'b0, full},    {7'b0, tbl[i].e_cnt == 3'd4});
        end

        // Duplicate press of 3U before consumption collapses to one entry.
        cycle(1'b1, 6'b000100, 1'b0);
        cycle(1'b1, 6'b000000, 1'b0);
        cycle(1'b1, 6'b000100, 1'b0);
        cycle(1'b1, 6'b000000, 1'b0);
        check("dup_count", {5'b0, count}, 8'd1);
        cycle(1'b1, 6'b000000, 1'b1);
        check("dup_pop_count", {5'b0, count}, 8'd0);
        check("dup_pop_pending", {2'b0, pending}, 8'd0);
        check("dup_pop_din", {5'b0, din}, 8'd0);

        // Press arriving in the cycle its own code pops is re-queued.
        cycle(1'b1, 6'b000100, 1'b0);
        cycle(1'b1, 6'b000000, 1'b0);
        cycle(1'b1, 6'b000100, 1'b1);
        check("requeue_pending", {2'b0, pending}, 8'b000100);
        check("requeue_count0", {5'b0, count}, 8'd0);
        cycle(1'b1, 6'b000000, 1'b0);
        check("requeue_count1", {5'b0, count}, 8'd1);
        check("requeue_din", {5'b0, din}, 8'b011);
        cycle(1'b1, 6'b000000, 1'b1);

        // All six calls with DEPTH=4: fill, then push/pop while full.
        cycle(1'b1, 6'b111111, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 6'b111111, 1'b0);
        check("fill_full", {7'b0, full}, 8'd1);
        check("fill_count", {5'b0, count}, 8'd4);
        check("fill_pending", {2'b0, pending}, 8'b111111);
        obs.push_back(din);
        cycle(1'b1, 6'b111111, 1'b1);
        check("pushpop_count_a", {5'b0, count}, 8'd4);
        cycle(1'b1, 6'b111111, 1'b0);
        obs.push_back(din);
        cycle(1'b1, 6'b111111, 1'b1);
        check("pushpop_count_b", {5'b0, count}, 8'd4);
        for (int i = 0; i < 4; i++) begin
            obs.push_back(din);
            cycle(1'b1, 6'b000000, 1'b1);
        end
        check("drain_count", {5'b0, count}, 8'd0);
        check("drain_pending", {2'b0, pending}, 8'd0);
        for (int i = 0; i < 6; i++)
            check($sformatf("order%0d", i), {5'b0, obs[i]}, {5'b0, exp_order[i]});

        // Reset mid-operation with a button held through it.
        cycle(1'b1, 6'b101001, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 6'b000000, 1'b0);
        check("pre_reset_count", {5'b0, count}, 8'd3);
        cycle(1'b1, 6'b000010, 1'b0);
        cycle(1'b0, 6'b000010, 1'b0);
        check("reset_q_empty", {7'b0, q_empty}, 8'd1);
        check("reset_din", {5'b0, din}, 8'd0);
        check("reset_pending", {2'b0, pending}, 8'd0);
        check("reset_full", {7'b0, full}, 8'd0);
        cycle(1'b0, 6'b000010, 1'b0);
        cycle(1'b1, 6'b000010, 1'b0);
        check("held_pending", {2'b0, pending}, 8'b000010);
        cycle(1'b1, 6'b000010, 1'b0);
        check("held_din", {5'b0, din}, 8'b010);
        check("held_count", {5'b0, count}, 8'd1);
        cycle(1'b1, 6'b000000, 1'b1);

        // Randomized traffic: sparse button toggles, occasional reset.
        for (int i = 0; i < 500; i++) begin
            r_rand = ($urandom_range(0, 59) != 0);
            b_rand = btn ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
            d_rand = (i < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            cycle(r_rand, b_rand, d_rand);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
